// File: rtl/wgt_load_sequencer_if.sv
// Weight-buffer read handshake between the preload sequencer (master)
// and the weight SRAM / array loader (slave).
interface wgt_load_sequencer_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int CNT_WIDTH  = 5
) ();

  logic [ADDR_WIDTH-1:0] wgt_addr;
  logic                  addr_valid;
  logic                  ready;
  logic [CNT_WIDTH-1:0]  tap_idx;
  logic [CNT_WIDTH-1:0]  filter_idx;
  logic                  last_tap;

  modport master (
    output wgt_addr,
    output addr_valid,
    output tap_idx,
    output filter_idx,
    output last_tap,
    input  ready
  );

  modport slave (
    input  wgt_addr,
    input  addr_valid,
    input  tap_idx,
    input  filter_idx,
    input  last_tap,
    output ready
  );

endinterface

// File: rtl/wgt_load_sequencer.sv
// Weight preload sequencer for one systolic-array layer.
// Walks every filter and every kernel tap and issues weight-buffer read
// addresses over a valid/ready handshake. Weights are interleaved:
// filter f, tap t sits at base_addr + t*ADDR_STRIDE + f.
// A one-cycle bubble (GAP) separates consecutive filters so the array can
// swap filters.
// Optional build macro: WGT_SEQ_STALL_CNT_EN enables the 16-bit saturating
// ready-stall counter; without it o_stall_cnt is tied to zero.
module wgt_load_sequencer #(
  parameter int KERNEL_SIZE = 3,
  parameter int NO_CHANNEL  = 3,
  parameter int NO_FILTER   = 16,
  parameter int ADDR_WIDTH  = 9,
  parameter int ADDR_STRIDE = 16,
  parameter int CNT_WIDTH   = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  wgt_load_sequencer_if.master  bus,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [15:0]           o_stall_cnt
);

  localparam int TAPS = KERNEL_SIZE * KERNEL_SIZE * NO_CHANNEL;
  localparam logic [CNT_WIDTH-1:0]  TAP_LAST  = CNT_WIDTH'(TAPS - 1);
  localparam logic [CNT_WIDTH-1:0]  FILT_LAST = CNT_WIDTH'(NO_FILTER - 1);
  localparam logic [CNT_WIDTH-1:0]  CNT_ZERO  = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] STRIDE    = ADDR_WIDTH'(ADDR_STRIDE);
  // With a single-tap kernel the first tap of a filter is also its last.
  localparam logic FIRST_IS_LAST = (TAPS == 1) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_wgt_addr;    // row pointer: address currently offered
  logic [ADDR_WIDTH-1:0] r_filt_base;   // layer base, filter offsets are added to it
  logic                  r_addr_valid;
  logic [CNT_WIDTH-1:0]  r_tap_idx;
  logic [CNT_WIDTH-1:0]  r_filter_idx;
  logic                  r_last_tap;
  logic                  r_busy;
  logic                  r_done;

  logic                  w_start_acc;
  logic                  w_abort;
  logic                  w_accept;
  logic                  w_tap_last;
  logic                  w_filt_last;
  logic [CNT_WIDTH-1:0]  w_tap_nxt;
  logic [CNT_WIDTH-1:0]  w_filter_nxt;
  logic [ADDR_WIDTH-1:0] w_step_addr;
  logic [ADDR_WIDTH-1:0] w_gap_addr;

  // A start is honoured only from IDLE and loses against a simultaneous abort.
  assign w_start_acc  = (r_state == S_IDLE) & i_start & ~i_abort;
  // Abort only matters while a preload is in flight.
  assign w_abort      = (r_state != S_IDLE) & i_abort;
  assign w_accept     = r_addr_valid & bus.ready;
  assign w_tap_last   = (r_tap_idx == TAP_LAST);
  assign w_filt_last  = (r_filter_idx == FILT_LAST);
  assign w_tap_nxt    = r_tap_idx + CNT_ONE;
  assign w_filter_nxt = r_filter_idx + CNT_ONE;
  // Both address updates wrap modulo 2^ADDR_WIDTH by construction.
  assign w_step_addr  = r_wgt_addr + STRIDE;
  assign w_gap_addr   = r_filt_base + ADDR_WIDTH'(w_filter_nxt);

  // Sequencer FSM: state and every handshake/status output registered together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_wgt_addr   <= ADDR_ZERO;
      r_filt_base  <= ADDR_ZERO;
      r_addr_valid <= 1'b0;
      r_tap_idx    <= CNT_ZERO;
      r_filter_idx <= CNT_ZERO;
      r_last_tap   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else if (w_abort) begin
      // Abort beats any accept in the same cycle and never produces done.
      r_state      <= S_IDLE;
      r_wgt_addr   <= ADDR_ZERO;
      r_filt_base  <= ADDR_ZERO;
      r_addr_valid <= 1'b0;
      r_tap_idx    <= CNT_ZERO;
      r_filter_idx <= CNT_ZERO;
      r_last_tap   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start_acc) begin
            r_state      <= S_ISSUE;
            r_wgt_addr   <= i_base_addr;
            r_filt_base  <= i_base_addr;
            r_addr_valid <= 1'b1;
            r_tap_idx    <= CNT_ZERO;
            r_filter_idx <= CNT_ZERO;
            r_last_tap   <= FIRST_IS_LAST;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
          end else begin
            r_state      <= S_IDLE;
            r_addr_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
          end
        end

        S_ISSUE: begin
          if (!w_accept) begin
            // Downstream stalled: everything holds.
            r_state <= S_ISSUE;
          end else if (!w_tap_last) begin
            r_tap_idx  <= w_tap_nxt;
            r_wgt_addr <= w_step_addr;
            r_last_tap <= (w_tap_nxt == TAP_LAST);
          end else if (!w_filt_last) begin
            // Filter finished: bubble, then restart taps for the next filter.
            r_state      <= S_GAP;
            r_addr_valid <= 1'b0;
            r_filter_idx <= w_filter_nxt;
            r_tap_idx    <= CNT_ZERO;
            r_wgt_addr   <= w_gap_addr;
            r_last_tap   <= FIRST_IS_LAST;
          end else begin
            r_state      <= S_DONE;
            r_addr_valid <= 1'b0;
            r_last_tap   <= 1'b0;
            r_done       <= 1'b1;
          end
        end

        S_GAP: begin
          r_state      <= S_ISSUE;
          r_addr_valid <= 1'b1;
        end

        S_DONE: begin
          // Single-cycle done pulse; return to the reset-like idle picture.
          r_state      <= S_IDLE;
          r_done       <= 1'b0;
          r_busy       <= 1'b0;
          r_addr_valid <= 1'b0;
          r_wgt_addr   <= ADDR_ZERO;
          r_tap_idx    <= CNT_ZERO;
          r_filter_idx <= CNT_ZERO;
          r_last_tap   <= 1'b0;
        end

        default: begin
          r_state      <= S_IDLE;
          r_wgt_addr   <= ADDR_ZERO;
          r_filt_base  <= ADDR_ZERO;
          r_addr_valid <= 1'b0;
          r_tap_idx    <= CNT_ZERO;
          r_filter_idx <= CNT_ZERO;
          r_last_tap   <= 1'b0;
          r_busy       <= 1'b0;
          r_done       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.wgt_addr   = r_wgt_addr;
  assign bus.addr_valid = r_addr_valid;
  assign bus.tap_idx    = r_tap_idx;
  assign bus.filter_idx = r_filter_idx;
  assign bus.last_tap   = r_last_tap;
  assign o_busy         = r_busy;
  assign o_done         = r_done;

`ifdef WGT_SEQ_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  // Stall counter: counts offered-but-not-accepted cycles, saturating, reset per layer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= 16'h0000;
    end else if (w_start_acc) begin
      r_stall_cnt <= 16'h0000;
    end else if (r_addr_valid && !bus.ready && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'h0001;
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

  assign o_stall_cnt = r_stall_cnt;
`else
  assign o_stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_wgt_load_sequencer.sv
// Self-checking bench for wgt_load_sequencer with default parameters.
// A behavioural model tracks the expected (filter, tap) position and phase;
// addresses are computed directly from the interleaved layout formula.
module tb_wgt_load_sequencer;

  localparam int KS    = 3;
  localparam int NC    = 3;
  localparam int NF    = 16;
  localparam int AW    = 9;
  localparam int AS    = 16;
  localparam int CW    = 5;
  localparam int TAPS  = KS * KS * NC;
  localparam int TOTAL = NF * TAPS;

  localparam int PH_IDLE  = 0;
  localparam int PH_ISSUE = 1;
  localparam int PH_GAP   = 2;
  localparam int PH_DONE  = 3;

  logic          clk;
  logic          rst_n;
  logic          i_start;
  logic          i_abort;
  logic [AW-1:0] i_base_addr;
  logic          o_busy;
  logic          o_done;
  logic [15:0]   o_stall_cnt;

  int checks   = 0;
  int failures = 0;

  wgt_load_sequencer_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

  wgt_load_sequencer #(
    .KERNEL_SIZE(KS), .NO_CHANNEL(NC), .NO_FILTER(NF),
    .ADDR_WIDTH(AW), .ADDR_STRIDE(AS), .CNT_WIDTH(CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (i_start),
    .i_abort     (i_abort),
    .i_base_addr (i_base_addr),
    .bus         (bus),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_stall_cnt (o_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int exp_addr(input int base, input int t, input int f);
    return (base + t * AS + f) % (1 << AW);
  endfunction

  // mode 0: ready always high; 1: low/high alternating per offered address;
  // 2: random ready. abort_idx >= 0 aborts while that address is offered.
  task automatic run_seq(input int base, input int mode, input int abort_idx, input int extra_start_cyc);
    int  idx, phase, cyc, acc, dones, done_cyc, stall_exp, t, f;
    bit  r, tog, ab, finished;
    idx = 0; acc = 0; dones = 0; done_cyc = -1; stall_exp = 0;
    tog = 1'b0; finished = 1'b0; r = 1'b0; ab = 1'b0;
    @(negedge clk);
    i_base_addr = AW'(base);
    i_start     = 1'b1;
    bus.ready   = 1'b0;
    @(posedge clk);
    phase = PH_ISSUE;
    cyc   = 1;
    while (!finished && cyc < 3000) begin
      @(negedge clk);
      i_start     = (cyc == extra_start_cyc);
      i_base_addr = AW'($urandom);
      case (mode)
        0: r = 1'b1;
        1: begin
          if (phase == PH_ISSUE) begin
            r = tog;
            tog = ~tog;
          end else begin
            r = 1'b1;
          end
        end
        default: r = ($urandom_range(0, 3) != 0);
      endcase
      bus.ready = r;
      ab = (abort_idx >= 0) && (phase == PH_ISSUE) && (idx == abort_idx);
      i_abort = ab;

      check_val("valid", {31'd0, bus.addr_valid}, (phase == PH_ISSUE) ? 32'd1 : 32'd0);
      check_val("busy", {31'd0, o_busy}, 32'd1);
      check_val("done", {31'd0, o_done}, (phase == PH_DONE) ? 32'd1 : 32'd0);
`ifdef WGT_SEQ_STALL_CNT_EN
      check_val("stall_cnt", {16'd0, o_stall_cnt}, stall_exp);
`else
      check_val("stall_cnt", {16'd0, o_stall_cnt}, 32'd0);
`endif
      if (phase == PH_ISSUE) begin
        t = idx % TAPS;
        f = idx / TAPS;
        check_val("wgt_addr", {23'd0, bus.wgt_addr}, exp_addr(base, t, f));
        check_val("tap_idx", {27'd0, bus.tap_idx}, t);
        check_val("filter_idx", {27'd0, bus.filter_idx}, f);
        check_val("last_tap", {31'd0, bus.last_tap}, (t == TAPS - 1) ? 32'd1 : 32'd0);
      end
      if (o_done === 1'b1) begin
        dones++;
        done_cyc = cyc;
      end
      if (bus.addr_valid === 1'b1 && r && !ab) acc++;

      @(posedge clk);
      if (ab) begin
        phase = PH_IDLE;
        finished = 1'b1;
      end else begin
        case (phase)
          PH_ISSUE: begin
            if (r) begin
              idx++;
              if (idx == TOTAL) phase = PH_DONE;
              else if (idx % TAPS == 0) phase = PH_GAP;
            end else if (stall_exp < 65535) begin
              stall_exp++;
            end
          end
          PH_GAP:  phase = PH_ISSUE;
          PH_DONE: begin
            phase = PH_IDLE;
            finished = 1'b1;
          end
          default: finished = 1'b1;
        endcase
      end
      cyc++;
    end

    @(negedge clk);
    i_start = 1'b0;
    i_abort = 1'b0;
    bus.ready = 1'b0;
    if (!finished) check_val("timeout", 32'd0, 32'd1);
    check_val("idle_valid", {31'd0, bus.addr_valid}, 32'd0);
    check_val("idle_busy", {31'd0, o_busy}, 32'd0);
    check_val("idle_done", {31'd0, o_done}, 32'd0);
`ifdef WGT_SEQ_STALL_CNT_EN
    check_val("stall_hold", {16'd0, o_stall_cnt}, stall_exp);
`endif
    if (abort_idx >= 0) begin
      check_val("abort_no_done", dones, 32'd0);
      check_val("abort_accepts", acc, abort_idx);
      check_val("abort_addr", {23'd0, bus.wgt_addr}, 32'd0);
      check_val("abort_tap", {27'd0, bus.tap_idx}, 32'd0);
      check_val("abort_filter", {27'd0, bus.filter_idx}, 32'd0);
    end else begin
      check_val("done_count", dones, 32'd1);
      check_val("accepts", acc, TOTAL);
      if (mode == 0)
        check_val("done_latency", done_cyc + 1, 1 + NF * TAPS + (NF - 1) + 1);
`ifdef WGT_SEQ_STALL_CNT_EN
      if (mode == 1) check_val("stall_total", {16'd0, o_stall_cnt}, TOTAL);
`endif
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_val("post_done", {31'd0, o_done}, 32'd0);
      check_val("post_valid", {31'd0, bus.addr_valid}, 32'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    i_start = 1'b0;
    i_abort = 1'b0;
    i_base_addr = '0;
    bus.ready = 1'b0;
    #12;
    check_val("rst_valid", {31'd0, bus.addr_valid}, 32'd0);
    check_val("rst_addr", {23'd0, bus.wgt_addr}, 32'd0);
    check_val("rst_tap", {27'd0, bus.tap_idx}, 32'd0);
    check_val("rst_filter", {27'd0, bus.filter_idx}, 32'd0);
    check_val("rst_last", {31'd0, bus.last_tap}, 32'd0);
    check_val("rst_busy", {31'd0, o_busy}, 32'd0);
    check_val("rst_done", {31'd0, o_done}, 32'd0);
    check_val("rst_stall", {16'd0, o_stall_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_val("idle_after_rst", {31'd0, o_busy}, 32'd0);

    run_seq(0, 0, -1, -1);
    run_seq(200, 0, -1, -1);
    run_seq(200, 1, -1, -1);
    run_seq(int'($urandom_range(0, 511)), 2, -1, 57);
    run_seq(0, 0, 3 * TAPS + 10, -1);
    run_seq(0, 0, -1, 100);

    // start together with abort while idle: start must be ignored
    @(negedge clk);
    i_start = 1'b1;
    i_abort = 1'b1;
    i_base_addr = 9'd3;
    @(negedge clk);
    i_start = 1'b0;
    i_abort = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_val("start_abort_busy", {31'd0, o_busy}, 32'd0);
      check_val("start_abort_valid", {31'd0, bus.addr_valid}, 32'd0);
      @(negedge clk);
    end

    // asynchronous reset in the middle of ISSUE
    i_base_addr = 9'd5;
    i_start = 1'b1;
    bus.ready = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (20) @(negedge clk);
    check_val("pre_rst_busy", {31'd0, o_busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_valid", {31'd0, bus.addr_valid}, 32'd0);
    check_val("arst_addr", {23'd0, bus.wgt_addr}, 32'd0);
    check_val("arst_tap", {27'd0, bus.tap_idx}, 32'd0);
    check_val("arst_filter", {27'd0, bus.filter_idx}, 32'd0);
    check_val("arst_busy", {31'd0, o_busy}, 32'd0);
    check_val("arst_done", {31'd0, o_done}, 32'd0);
    check_val("arst_stall", {16'd0, o_stall_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_val("arst_idle_busy", {31'd0, o_busy}, 32'd0);
      check_val("arst_idle_done", {31'd0, o_done}, 32'd0);
    end

    run_seq(int'($urandom_range(0, 511)), 2, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
